// File: rtl/rdid_spi_master_pkg.sv
// Shared definitions for the RDID SPI master: state encoding, command constants
// and the byte/bit counts of a JEDEC identification read.
package rdid_spi_master_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CS_SETUP = 3'd1;
   localparam logic [2:0] ST_XFER     = 3'd2;
   localparam logic [2:0] ST_CS_HOLD  = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      CS_SETUP = ST_CS_SETUP,
      XFER     = ST_XFER,
      CS_HOLD  = ST_CS_HOLD,
      DONE     = ST_DONE
   } state_t;

   localparam logic [7:0] RDID_OPCODE_DEFAULT = 8'h9F;
   localparam int         OPCODE_BITS         = 8;
   localparam int         JEDEC_BYTES         = 3;
   localparam int         RX_BITS             = JEDEC_BYTES * 8;
   localparam int         TOTAL_BITS          = OPCODE_BITS + RX_BITS;
   localparam int         BIT_CNT_W           = $clog2(TOTAL_BITS);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(TOTAL_BITS - 1);

   // Byte 0 is the first byte on the wire (manufacturer), held in the top of rx.
   function automatic logic [7:0] jedec_byte(input logic [RX_BITS-1:0] rx, input int idx);
      return rx[RX_BITS-1-8*idx -: 8];
   endfunction

endpackage

// File: rtl/rdid_spi_master_spi_tick_gen.sv
// Free-running 0..CLK_DIV-1 divider for SPI bit timing; tick marks the last
// count of each SCK half-period. Clearing restarts the half-period.
module spi_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clear || !enable) begin
         cnt_next = '0;
      end else if (cnt_reg == CNT_MAX) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign tick = enable && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/rdid_spi_master.sv
// SPI mode-0 master that issues the Read-Identification command on a start
// pulse and returns the 3-byte JEDEC ID with a one-cycle done strobe.
module rdid_spi_master
   import rdid_spi_master_pkg::*;
#(
   parameter int         CLK_DIV     = 4,
   parameter logic [7:0] RDID_OPCODE = RDID_OPCODE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       spi_miso,
   output logic       spi_sck,
   output logic       spi_cs_n,
   output logic       spi_mosi,
   output logic       busy,
   output logic       done,
   output logic [7:0] mfg_id,
   output logic [7:0] mem_type,
   output logic [7:0] mem_cap
);

   state_t                  state_reg, state_next;
   logic                    cs_n_reg, cs_n_next;
   logic                    sck_reg, sck_next;
   logic                    mosi_reg, mosi_next;
   logic                    busy_reg, busy_next;
   logic                    done_reg, done_next;
   logic [OPCODE_BITS-1:0]  tx_reg, tx_next;
   logic [RX_BITS-1:0]      rx_reg, rx_next;
   logic [BIT_CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
   logic                    id_load;
   logic                    tick;
   logic                    cnt_clear;

   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .enable  (state_reg != IDLE),
      .clear   (cnt_clear),
      .tick    (tick)
   );

   // Every state change restarts the divider so each phase lasts whole half-periods.
   assign cnt_clear = (state_next != state_reg);

   always_comb begin
      state_next   = state_reg;
      cs_n_next    = cs_n_reg;
      sck_next     = sck_reg;
      mosi_next    = mosi_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      tx_next      = tx_reg;
      rx_next      = rx_reg;
      bit_cnt_next = bit_cnt_reg;
      id_load      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = CS_SETUP;
               cs_n_next    = 1'b0;
               busy_next    = 1'b1;
               sck_next     = 1'b0;
               tx_next      = RDID_OPCODE;
               mosi_next    = RDID_OPCODE[7];
               bit_cnt_next = '0;
            end
         end
         CS_SETUP: begin
            if (tick) begin
               state_next = XFER;
            end
         end
         XFER: begin
            if (tick) begin
               if (!sck_reg) begin
                  // Rising edge: slave data is stable, shift it in MSB first.
                  sck_next = 1'b1;
                  rx_next  = {rx_reg[RX_BITS-2:0], spi_miso};
               end else begin
                  sck_next     = 1'b0;
                  tx_next      = {tx_reg[OPCODE_BITS-2:0], 1'b0};
                  mosi_next    = tx_reg[OPCODE_BITS-2];
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == LAST_BIT) begin
                     state_next = CS_HOLD;
                  end
               end
            end
         end
         CS_HOLD: begin
            if (tick) begin
               state_next = DONE;
               cs_n_next  = 1'b1;
               done_next  = 1'b1;
               id_load    = 1'b1;
            end
         end
         DONE: begin
            if (tick) begin
               state_next = IDLE;
               busy_next  = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
            cs_n_next  = 1'b1;
            sck_next   = 1'b0;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         cs_n_reg    <= 1'b1;
         sck_reg     <= 1'b0;
         mosi_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         tx_reg      <= '0;
         rx_reg      <= '0;
         bit_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cs_n_reg    <= cs_n_next;
         sck_reg     <= sck_next;
         mosi_reg    <= mosi_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         tx_reg      <= tx_next;
         rx_reg      <= rx_next;
         bit_cnt_reg <= bit_cnt_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < JEDEC_BYTES; gi++) begin : g_id
         logic [7:0] byte_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               byte_reg <= '0;
            end else if (id_load) begin
               byte_reg <= jedec_byte(rx_reg, gi);
            end
         end
      end
   endgenerate

   assign spi_cs_n = cs_n_reg;
   assign spi_sck  = sck_reg;
   assign spi_mosi = mosi_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign mfg_id   = g_id[0].byte_reg;
   assign mem_type = g_id[1].byte_reg;
   assign mem_cap  = g_id[2].byte_reg;

endmodule
